// File: rtl/lcd_pkg.sv
// Shared LCD word format and arbiter state encodings.
// Used by the SPI arbiter and by the lcd_write/centerctrl users.
package lcd_pkg;

  localparam int unsigned WORD_W = 9;
  localparam int unsigned DC_BIT = 8;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } lcd_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  function automatic lcd_word_t word_unpack(input logic [WORD_W-1:0] w);
    lcd_word_t r;
    r.dc   = w[DC_BIT];
    r.data = w[DC_BIT-1:0];
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: bit 0 has absolute priority, the rest are
// searched round-robin starting after the last grant.
module rr_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] last,
  output logic             pick_vld,
  output logic [IDX_W-1:0] pick_idx,
  output logic [NREQ-1:0]  pick_oh
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    cand     = '0;
    if (mask[0]) begin
      pick_vld   = 1'b1;
      pick_oh[0] = 1'b1;
    end else begin
      // Candidates cycle through 1..NREQ-1, first one is last+1 (0 wraps to 1).
      for (int k = 0; k < int'(NREQ) - 1; k++) begin
        cand = IDX_W'((32'(last) + 32'(k)) % (NREQ - 1) + 1);
        if (!pick_vld && mask[cand]) begin
          pick_vld      = 1'b1;
          pick_idx      = cand;
          pick_oh[cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Transaction-locked arbiter sharing one lcd_write serializer between several
// producers; requester 0 (init) is exclusive until init_done, watchdog on wr_done.
module lcd_spi_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   init_done,
  input  logic [NREQ-1:0]        req,
  input  logic [WORD_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_wr,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        req_done,
  output logic [WORD_W-1:0]      spi_data,
  output logic                   en_write,
  input  logic                   wr_done,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   req_done_q, req_done_d;
  lcd_word_t         spi_data_q, spi_data_d;
  logic              en_write_q, en_write_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic [NREQ-1:0]   elig;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [NREQ-1:0]   pick_oh;

  logic              own_req;
  logic              own_wr;
  logic              own_elig;
  logic [WORD_W-1:0] own_word;
  logic [NREQ-1:0]   owner_oh;
  logic              wd_expire;

  assign elig = init_done ? req : {{(NREQ-1){1'b0}}, req[0]};

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .mask     (elig),
    .last     (last_q),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx),
    .pick_oh  (pick_oh)
  );

  // Owner-side view of the request bus.
  always_comb begin
    own_req  = 1'b0;
    own_wr   = 1'b0;
    own_word = '0;
    owner_oh = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_req     = req[i];
        own_wr      = req_wr[i];
        own_word    = req_data[i*WORD_W +: WORD_W];
        owner_oh[i] = 1'b1;
      end
    end
  end

  assign own_elig  = own_req && (init_done || (owner_q == '0));
  assign wd_expire = (wdog_q == WD_W'(1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    req_done_d = '0;
    spi_data_d = spi_data_q;
    en_write_d = 1'b0;
    overrun_d  = overrun_q;
    timeout_d  = 1'b0;
    wdog_d     = wdog_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_OWN;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          last_d  = pick_idx;
        end
      end

      ST_OWN: begin
        if (own_wr) begin
          // A word strobed together with a release is still forwarded.
          spi_data_d = word_unpack(own_word);
          en_write_d = 1'b1;
          wdog_d     = WD_W'(TIMEOUT);
          if (own_elig) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_DRAIN;
            gnt_d   = '0;
          end
        end else if (!own_elig) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end

      ST_BUSY: begin
        wdog_d = (wdog_q != '0) ? wdog_q - WD_W'(1) : '0;
        if (own_wr) begin
          overrun_d = 1'b1;
        end
        if (wr_done) begin
          req_done_d = owner_oh;
          if (own_elig) begin
            state_d = ST_OWN;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          gnt_d     = '0;
        end else if (!own_elig) begin
          state_d = ST_DRAIN;
          gnt_d   = '0;
        end
      end

      ST_DRAIN: begin
        wdog_d = (wdog_q != '0) ? wdog_q - WD_W'(1) : '0;
        if (own_wr) begin
          overrun_d = 1'b1;
        end
        if (wr_done) begin
          req_done_d = owner_oh;
          state_d    = ST_IDLE;
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= '0;
      gnt_q      <= '0;
      req_done_q <= '0;
      spi_data_q <= '0;
      en_write_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      req_done_q <= req_done_d;
      spi_data_q <= spi_data_d;
      en_write_q <= en_write_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      wdog_q     <= wdog_d;
    end
  end

  assign gnt      = gnt_q;
  assign req_done = req_done_q;
  assign spi_data = spi_data_q;
  assign en_write = en_write_q;
  assign overrun  = overrun_q;
  assign timeout  = timeout_q;

endmodule
